// File: rtl/pingpong_frame_writer_pkg.sv
// Shared definitions for the ping-pong frame writer: bank encodings and writer states.
package pingpong_frame_writer_pkg;

  localparam int NO_BANKS = 2;

  // One-hot bank codes; must match the bankRAM rd_bank_select decode.
  localparam logic [1:0] BANK0 = 2'b01;
  localparam logic [1:0] BANK1 = 2'b10;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } wr_state_t;

  function automatic logic [1:0] bank_onehot(input logic bank);
    return bank ? BANK1 : BANK0;
  endfunction

endpackage

// File: rtl/pingpong_frame_writer_frame_addr_counter.sv
// Sample address counter for one bank: counts 0..frame_len-1 on enable, pulses wrap on the last slot.
module pingpong_frame_writer_frame_addr_counter #(
  parameter int address_width = 12,
  parameter int frame_len     = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic [address_width-1:0] count,
  output logic                     wrap
);

  localparam logic [address_width-1:0] LAST = address_width'(frame_len - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pingpong_frame_writer.sv
// Two-bank write controller: packs a valid-qualified stream into frames, hands full banks
// to the consumer oldest-first, and drops/counts samples while both banks are full.
module pingpong_frame_writer
  import pingpong_frame_writer_pkg::*;
#(
  parameter int word_width    = 4,
  parameter int address_width = 12,
  parameter int frame_len     = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [word_width-1:0]    in_data,
  output logic [1:0]               wr_bank_select,
  output logic [1:0]               wr_en,
  output logic [address_width-1:0] wr_address,
  output logic [word_width-1:0]    wr_data,
  output logic [1:0]               rd_bank_select,
  output logic                     frame_avail,
  input  logic                     frame_done,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  wr_state_t               state, state_n;
  logic                    wb, wb_n;
  logic                    rb, rb_n;
  logic [NO_BANKS-1:0]     full, full_n;
  logic                    accept, drop, release_frame;
  logic [address_width-1:0] addr;
  logic                    addr_wrap;

  assign accept        = (state == FILL) && in_valid;
  assign drop          = (state == STALL) && in_valid;
  assign release_frame = frame_done && full[rb];

  pingpong_frame_writer_frame_addr_counter #(
    .address_width(address_width),
    .frame_len    (frame_len)
  ) u_addr_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .count(addr),
    .wrap (addr_wrap)
  );

  // Release and completion are applied together, so a frame finishing while the
  // other bank is handed back swaps banks without stalling.
  always_comb begin
    full_n = full;
    if (release_frame) full_n[rb] = 1'b0;
    if (addr_wrap)     full_n[wb] = 1'b1;

    state_n = state;
    wb_n    = wb;
    case (state)
      FILL: begin
        if (addr_wrap) begin
          if (!full_n[~wb]) wb_n = ~wb;
          else              state_n = STALL;
        end
      end
      STALL: begin
        if (!full_n[~wb]) begin
          wb_n    = ~wb;
          state_n = FILL;
        end
      end
      default: state_n = FILL;
    endcase

    // Keep presenting the older bank; move only once it is no longer full.
    rb_n = rb;
    if (!full_n[rb] && full_n[~rb]) rb_n = ~rb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FILL;
      wb             <= 1'b0;
      rb             <= 1'b0;
      full           <= '0;
      wr_bank_select <= '0;
      wr_en          <= '0;
      wr_address     <= '0;
      wr_data        <= '0;
      rd_bank_select <= '0;
      frame_avail    <= 1'b0;
      overflow       <= 1'b0;
      drop_count     <= '0;
    end else begin
      state <= state_n;
      wb    <= wb_n;
      rb    <= rb_n;
      full  <= full_n;

      wr_en <= accept ? bank_onehot(wb) : 2'b00;
      if (accept) begin
        wr_bank_select <= bank_onehot(wb);
        wr_address     <= addr;
        wr_data        <= in_data;
      end else begin
        wr_bank_select <= (state_n == FILL) ? bank_onehot(wb_n) : 2'b00;
      end

      rd_bank_select <= full_n[rb_n] ? bank_onehot(rb_n) : 2'b00;
      frame_avail    <= full_n[rb_n];

      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_frame_writer.sv
// Bench for pingpong_frame_writer: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based model of the bank hand-off.
module tb_pingpong_frame_writer;

  localparam int WW = 4;
  localparam int AW = 3;
  localparam int FL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [WW-1:0] in_data = '0;
  logic          frame_done = 1'b0;
  logic [1:0]    wr_bank_select, wr_en, rd_bank_select;
  logic [AW-1:0] wr_address;
  logic [WW-1:0] wr_data;
  logic          frame_avail, overflow;
  logic [15:0]   drop_count;

  int vectors = 0;
  int miscompares = 0;

  pingpong_frame_writer #(.word_width(WW), .address_width(AW), .frame_len(FL)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .wr_bank_select(wr_bank_select),
    .wr_en         (wr_en),
    .wr_address    (wr_address),
    .wr_data       (wr_data),
    .rd_bank_select(rd_bank_select),
    .frame_avail   (frame_avail),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int            full_q[$];   // full banks, oldest (presented) first
  bit            m_wb;
  int            m_cnt;
  bit            m_stalled;
  logic [1:0]    e_wen, e_wbs, e_rd;
  logic [AW-1:0] e_addr;
  logic [WW-1:0] e_data;
  logic          e_av, e_ov;
  logic [15:0]   e_dc;

  function automatic logic [1:0] oh(input int b);
    return (b != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    full_q.delete();
    m_wb = 0; m_cnt = 0; m_stalled = 0;
    e_wen = 0; e_wbs = 0; e_rd = 0; e_addr = 0; e_data = 0;
    e_av = 0; e_ov = 0; e_dc = 0;
  endtask

  task automatic model_step(input bit v, input logic [WW-1:0] d, input bit fd);
    bit acc;
    acc = v && !m_stalled;
    if (v && m_stalled) begin
      e_ov = 1;
      if (e_dc != 16'hFFFF) e_dc = e_dc + 16'd1;
    end
    if (fd && full_q.size() > 0) void'(full_q.pop_front());
    e_wen = 2'b00;
    if (acc) begin
      e_wen  = oh(int'(m_wb));
      e_addr = AW'(m_cnt);
      e_data = d;
      if (m_cnt == FL - 1) begin
        full_q.push_back(int'(m_wb));
        m_cnt = 0;
        if (full_q.size() == 2) m_stalled = 1;
        else                    m_wb = !m_wb;
      end else begin
        m_cnt++;
      end
    end
    if (m_stalled && full_q.size() < 2) begin
      m_stalled = 0;
      m_wb = !m_wb;
      m_cnt = 0;
    end
    e_wbs = acc ? e_wen : (m_stalled ? 2'b00 : oh(int'(m_wb)));
    e_av  = full_q.size() > 0;
    e_rd  = e_av ? oh(full_q[0]) : 2'b00;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("wr_en", 32'(wr_en), 32'(e_wen));
    chk("wr_bank_select", 32'(wr_bank_select), 32'(e_wbs));
    chk("rd_bank_select", 32'(rd_bank_select), 32'(e_rd));
    chk("frame_avail", 32'(frame_avail), 32'(e_av));
    chk("overflow", 32'(overflow), 32'(e_ov));
    chk("drop_count", 32'(drop_count), 32'(e_dc));
    if (e_wen != 2'b00) begin
      chk("wr_address", 32'(wr_address), 32'(e_addr));
      chk("wr_data", 32'(wr_data), 32'(e_data));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_bank_select"}, 32'(wr_bank_select), 0);
    chk({tag, "_wr_address"}, 32'(wr_address), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_rd_bank_select"}, 32'(rd_bank_select), 0);
    chk({tag, "_frame_avail"}, 32'(frame_avail), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_drop_count"}, 32'(drop_count), 0);
  endtask

  // Drive one cycle of inputs, advance the model, compare just after the edge.
  task automatic step(input bit v, input logic [WW-1:0] d, input bit fd);
    in_valid   = v;
    in_data    = d;
    frame_done = fd;
    @(posedge clk);
    #1;
    model_step(v, d, fd);
    chk_model();
    in_valid   = 1'b0;
    frame_done = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          v;
    logic [WW-1:0] d;
    logic          fd;
    logic [1:0]    wen;
    logic [1:0]    wbs;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic [1:0]    rd;
    logic          av;
    logic          ov;
    logic [15:0]   dc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input int d, input logic fd, input logic [1:0] wen,
                     input logic [1:0] wbs, input int addr, input int data,
                     input logic [1:0] rd, input logic av, input logic ov, input int dc);
    vec_t r;
    r.v = v; r.d = WW'(d); r.fd = fd; r.wen = wen; r.wbs = wbs;
    r.addr = AW'(addr); r.data = WW'(data); r.rd = rd; r.av = av; r.ov = ov; r.dc = 16'(dc);
    tbl.push_back(r);
  endtask

  initial begin
    // Frame 1 into bank0: samples 1..8, presented right after the 8th is accepted.
    for (int i = 0; i < 8; i++)
      add(1, i + 1, 0, 2'b01, 2'b01, i, i + 1, (i == 7) ? 2'b01 : 2'b00, i == 7, 0, 0);
    // Frame 2 into bank1: samples 9..16, then both banks full.
    for (int i = 0; i < 8; i++)
      add(1, i + 9, 0, 2'b10, 2'b10, i, i + 9, 2'b01, 1, 0, 0);
    add(1, 1, 0, 2'b00, 2'b00, 7, 0, 2'b01, 1, 1, 1);   // 17th sample dropped
    add(0, 0, 1, 2'b00, 2'b01, 7, 0, 2'b10, 1, 1, 1);   // release bank0, bank1 presented
    add(1, 5, 0, 2'b01, 2'b01, 0, 5, 2'b10, 1, 1, 1);   // writes bank0 addr 0
    add(0, 0, 1, 2'b00, 2'b01, 0, 5, 2'b00, 0, 1, 1);   // release bank1, nothing full
    for (int i = 1; i < 8; i++)
      add(1, i, 0, 2'b01, 2'b01, i, i, (i == 7) ? 2'b01 : 2'b00, i == 7, 1, 1);
    for (int i = 0; i < 7; i++)
      add(1, i + 8, 0, 2'b10, 2'b10, i, i + 8, 2'b01, 1, 1, 1);
    // Completion of bank1 in the same cycle bank0 is released.
    add(1, 15, 1, 2'b10, 2'b10, 7, 15, 2'b10, 1, 1, 1);

    // ---- reset state ----
    model_reset();
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_all_zero("post_reset");

    // ---- table (tests 1-4) ----
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].fd);
      chk($sformatf("tbl%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].wen));
      chk($sformatf("tbl%0d_wr_bank_select", i), 32'(wr_bank_select), 32'(tbl[i].wbs));
      chk($sformatf("tbl%0d_wr_address", i), 32'(wr_address), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_wr_data", i), 32'(wr_data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_rd_bank_select", i), 32'(rd_bank_select), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_frame_avail", i), 32'(frame_avail), 32'(tbl[i].av));
      chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_drop_count", i), 32'(drop_count), 32'(tbl[i].dc));
    end

    // ---- test 5: gapped stream into bank0 ----
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0);
      step(0, 0, 0);
      step(1, WW'(k + 3), 0);
      chk("gap_wr_en", 32'(wr_en), 32'(2'b01));
      chk("gap_wr_address", 32'(wr_address), 32'(k));
    end
    chk("gap_stall_wr_bank_select", 32'(wr_bank_select), 32'(2'b01));
    step(0, 0, 0);
    chk("gap_stall_idle_wbs", 32'(wr_bank_select), 32'(2'b00));
    chk("gap_rd_bank_select", 32'(rd_bank_select), 32'(2'b10));

    // ---- test 6: async reset with bank0 full and bank1 at addr 5 ----
    step(0, 0, 1);
    for (int k = 0; k < 5; k++) step(1, WW'(k), 0);
    chk("pre_rst_address", 32'(wr_address), 4);
    chk("pre_rst_rd", 32'(rd_bank_select), 32'(2'b01));
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step(1, 4'h9, 0);
    chk("after_rst_wr_en", 32'(wr_en), 32'(2'b01));
    chk("after_rst_wr_address", 32'(wr_address), 0);
    chk("after_rst_wr_data", 32'(wr_data), 9);
    chk("after_rst_frame_avail", 32'(frame_avail), 0);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 9) < 6, WW'($urandom_range(0, 15)),
           $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
